// File: rtl/i2c_codec_responder.sv
// -----------------------------------------------------------------------------
// i2c_codec_responder
//
// Write-only I2C target for a codec register file. Each frame is START, a
// device byte (address DEV_ADDR, write), then two bytes forming a 16-bit word
// {HI, LO}. The word holds a 7-bit register index (word[15:9]) and 9 bits of
// data (word[8:0]). After the third byte's ACK slot the write is committed.
// SCL and SDA are oversampled in the i_clk domain. All bus decisions use the
// synchronised copies.
//
// Ports
//   i_clk        sole clock
//   i_rst        synchronous active-high reset
//   i_scl        I2C clock from the initiator (asynchronous)
//   i_sda        I2C data as seen on the bus (asynchronous)
//   o_sda_oen    1 = pull SDA low (ACK), 0 = release
//   o_wr_valid   one-cycle pulse: a register write was committed
//   o_reg_addr   register index of the committed write
//   o_reg_data   register data of the committed write
//   o_busy       high from START until STOP or abort
//   o_err        one-cycle pulse on protocol / index error
//   o_frame_cnt  count of committed writes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter logic [6:0] MAX_REG  = 7'd9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_frame_cnt
);

    // The reset register is committed even though it lies above MAX_REG.
    localparam logic [6:0] RESET_REG = 7'h0F;

    typedef enum logic [2:0] {
        IDLE,
        DEV,
        ACK_DEV,
        HI,
        ACK_HI,
        LO,
        ACK_LO,
        IGNORE
    } state_t;

    state_t state, state_n;

    // Two synchroniser flops per line plus one history flop for edge detection.
    logic scl_meta, scl_sync, scl_hist;
    logic sda_meta, sda_sync, sda_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= i_scl;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= i_sda;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    logic start_det, stop_det, scl_rise, scl_fall;

    assign start_det = scl_sync & scl_hist &  sda_hist & ~sda_sync;
    assign stop_det  = scl_sync & scl_hist & ~sda_hist &  sda_sync;
    // An SCL edge that coincides with START/STOP is not a data clock.
    assign scl_rise  =  scl_sync & ~scl_hist & ~(start_det | stop_det);
    assign scl_fall  = ~scl_sync &  scl_hist & ~(start_det | stop_det);

    // Byte assembly.
    logic [7:0] shreg;
    logic [7:0] hi_byte;
    logic [2:0] bit_cnt;
    logic       byte_full;
    logic       in_shift;
    logic [6:0] frame_idx;
    logic       idx_ok;

    assign in_shift  = (state == DEV) || (state == HI) || (state == LO);
    assign frame_idx = hi_byte[7:1];
    assign idx_ok    = (frame_idx <= MAX_REG) || (frame_idx == RESET_REG);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg     <= 8'h00;
            hi_byte   <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
        end else begin
            if (state == HI && state_n == ACK_HI) begin
                hi_byte <= shreg;
            end
            // Any state change or (repeated) START begins a fresh byte.
            if (start_det || state_n != state) begin
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else if (in_shift && scl_rise && !byte_full) begin
                shreg     <= {shreg[6:0], sda_sync};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_full <= (bit_cnt == 3'd7);
            end
        end
    end

    // Next-state and next-output logic.
    logic sda_oen_n;
    logic wr_valid_n;
    logic err_n;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        sda_oen_n  = o_sda_oen;
        wr_valid_n = 1'b0;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start_det) state_n = DEV;
            end
            IGNORE: begin
                if (start_det)     state_n = DEV;
                else if (stop_det) state_n = IDLE;
            end
            default: begin
                // DEV .. ACK_LO: a frame is in progress and not yet committed.
                if (start_det || stop_det) begin
                    state_n   = start_det ? DEV : IDLE;
                    sda_oen_n = 1'b0;
                    err_n     = 1'b1;
                end else if (scl_fall) begin
                    case (state)
                        DEV: begin
                            if (byte_full) begin
                                if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                                    state_n   = ACK_DEV;
                                    sda_oen_n = 1'b1;
                                end else begin
                                    // Another target's traffic is silent;
                                    // a read of this device is an error.
                                    state_n = IGNORE;
                                    err_n   = (shreg[7:1] == DEV_ADDR);
                                end
                            end
                        end
                        HI: begin
                            if (byte_full) begin
                                state_n   = ACK_HI;
                                sda_oen_n = 1'b1;
                            end
                        end
                        LO: begin
                            if (byte_full) begin
                                state_n   = ACK_LO;
                                sda_oen_n = 1'b1;
                            end
                        end
                        ACK_DEV: begin
                            state_n   = HI;
                            sda_oen_n = 1'b0;
                        end
                        ACK_HI: begin
                            state_n   = LO;
                            sda_oen_n = 1'b0;
                        end
                        ACK_LO: begin
                            state_n   = IGNORE;
                            sda_oen_n = 1'b0;
                            if (idx_ok) wr_valid_n = 1'b1;
                            else        err_n      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_sda_oen   <= 1'b0;
            o_wr_valid  <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_reg_addr  <= 7'd0;
            o_reg_data  <= 9'd0;
            o_frame_cnt <= 8'd0;
        end else begin
            state      <= state_n;
            o_sda_oen  <= sda_oen_n;
            o_wr_valid <= wr_valid_n;
            o_err      <= err_n;
            o_busy     <= (state_n != IDLE);
            if (wr_valid_n) begin
                // LO byte is still held in shreg during ACK_LO.
                o_reg_addr  <= frame_idx;
                o_reg_data  <= {hi_byte[0], shreg};
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
        end
    end

endmodule
